// File: rtl/d_en_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : d_en_pkg
//  Description : Shared constants, next-state select encoding and the
//                priority resolver for the enabled D flip-flop.
//                The optional set/clear feature is selected with D_EN_SR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package d_en_pkg;

    // Default data width of the register
    localparam int c_d_en_def_width_unused = 0;
    localparam int D_EN_DEF_WIDTH = 1;

    // Default reset level of every bit; the full-width default is a
    // replication of this bit.
    localparam logic D_EN_DEF_RST_BIT = 1'b0;

    // Next-state select for one storage bit
    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        LOAD  = 3'd1,
        RESET = 3'd2,
        SET   = 3'd3,
        CLEAR = 3'd4
    } d_en_sel_e;

    // Resolve the controls in priority order: reset, clear, set, enable.
    // Clear sits above set so that S=R=1 clears.
    function automatic d_en_sel_e d_en_resolve(
        input logic rst,
        input logic set_req,
        input logic clr_req,
        input logic en
    );
        d_en_sel_e sel;
        sel = HOLD;
        if (rst) begin
            sel = RESET;
        end else if (clr_req) begin
            sel = CLEAR;
        end else if (set_req) begin
            sel = SET;
        end else if (en) begin
            sel = LOAD;
        end
        return sel;
    endfunction

endpackage : d_en_pkg
`default_nettype wire

// File: rtl/d_en_bit.sv
`default_nettype none
// ============================================================================
//  Module      : d_en_bit
//  Description : One-bit edge-triggered storage cell with synchronous reset,
//                load enable and (when D_EN_SR_EN is defined) synchronous
//                set/clear inputs S and R.
//  Revision    : 1.0 - initial release
// ============================================================================
module d_en_bit
    import d_en_pkg::*;
#(
    parameter logic RST_BIT = D_EN_DEF_RST_BIT
) (
    input  logic C,
    input  logic rst,
    input  logic EN,
`ifdef D_EN_SR_EN
    input  logic S,
    input  logic R,
`endif
    input  logic D,
    output logic Q
);

    d_en_sel_e w_sel;
    logic      w_next;
    logic      r_q;

    // Pick the action for this edge and the value it produces
    always_comb begin
        w_next = r_q;
`ifdef D_EN_SR_EN
        w_sel  = d_en_resolve(rst, S, R, EN);
`else
        w_sel  = d_en_resolve(rst, 1'b0, 1'b0, EN);
`endif
        case (w_sel)
            RESET:   w_next = RST_BIT;
            CLEAR:   w_next = 1'b0;
            SET:     w_next = 1'b1;
            LOAD:    w_next = D;
            default: w_next = r_q;
        endcase
    end

    // Storage element, updated on the rising clock edge only
    always_ff @(posedge C) begin
        r_q <= w_next;
    end

    assign Q = r_q;

endmodule : d_en_bit
`default_nettype wire

// File: rtl/d_en.sv
`default_nettype none
// ============================================================================
//  Module      : d_en
//  Description : WIDTH-bit enabled D register with synchronous active-high
//                reset to RST_VAL and complementary output Qn = ~Q.
//                Define D_EN_SR_EN to add synchronous set (S) and clear (R)
//                inputs; clear wins over set, reset wins over both.
//  Revision    : 1.0 - initial release
// ============================================================================
module d_en
    import d_en_pkg::*;
#(
    parameter int               WIDTH   = D_EN_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{D_EN_DEF_RST_BIT}}
) (
    input  logic             C,
    input  logic             rst,
    input  logic             EN,
`ifdef D_EN_SR_EN
    input  logic             S,
    input  logic             R,
`endif
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    logic [WIDTH-1:0] w_q;

    // One storage cell per data bit, each with its own reset level
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            d_en_bit #(
                .RST_BIT (RST_VAL[i])
            ) u_bit (
                .C   (C),
                .rst (rst),
                .EN  (EN),
`ifdef D_EN_SR_EN
                .S   (S),
                .R   (R),
`endif
                .D   (D[i]),
                .Q   (w_q[i])
            );
        end
    endgenerate

    // Complement is purely combinational so it tracks Q with no extra stage
    assign Q  = w_q;
    assign Qn = ~w_q;

endmodule : d_en
`default_nettype wire

// File: tb/tb_d_en.sv
`default_nettype none
// ============================================================================
//  Module      : tb_d_en
//  Description : Directed self-checking bench for d_en (WIDTH=1 default,
//                WIDTH=8 with RST_VAL=8'hA5, and WIDTH=4 set/clear build
//                when D_EN_SR_EN is defined).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_d_en;

    logic       C;
    logic       rst;
    logic       EN;
    logic [0:0] d1;
    logic [7:0] d8;
    logic [0:0] q1, qn1;
    logic [7:0] q8, qn8;
`ifdef D_EN_SR_EN
    logic       S;
    logic       R;
    logic [3:0] d4;
    logic [3:0] q4, qn4;
`endif

    int checks;
    int failures;

    d_en u_w1 (
        .C   (C),
        .rst (rst),
        .EN  (EN),
`ifdef D_EN_SR_EN
        .S   (S),
        .R   (R),
`endif
        .D   (d1),
        .Q   (q1),
        .Qn  (qn1)
    );

    d_en #(
        .WIDTH   (8),
        .RST_VAL (8'hA5)
    ) u_w8 (
        .C   (C),
        .rst (rst),
        .EN  (EN),
`ifdef D_EN_SR_EN
        .S   (S),
        .R   (R),
`endif
        .D   (d8),
        .Q   (q8),
        .Qn  (qn8)
    );

`ifdef D_EN_SR_EN
    d_en #(
        .WIDTH   (4),
        .RST_VAL (4'h6)
    ) u_w4 (
        .C   (C),
        .rst (rst),
        .EN  (EN),
        .S   (S),
        .R   (R),
        .D   (d4),
        .Q   (q4),
        .Qn  (qn4)
    );
`endif

    // 100 ns period, first rising edge at 50 ns
    initial begin
        C = 1'b0;
        forever #50 C = ~C;
    end

    task automatic test_reset();
        // Inputs are already set to reset at time 0
        @(posedge C); #1;
        checks++;
        if (q1 !== 1'b0) begin failures++; $display("FAIL reset_q1 got=%b exp=0", q1); end
        checks++;
        if (qn1 !== 1'b1) begin failures++; $display("FAIL reset_qn1 got=%b exp=1", qn1); end
        checks++;
        if (q8 !== 8'hA5) begin failures++; $display("FAIL reset_q8 got=%h exp=a5", q8); end
        checks++;
        if (qn8 !== 8'h5A) begin failures++; $display("FAIL reset_qn8 got=%h exp=5a", qn8); end
    endtask

    task automatic test_load();
        @(negedge C);
        rst = 1'b0; EN = 1'b1; d1 = 1'b1; d8 = 8'h3C;
        @(posedge C); #1;
        checks++;
        if (q1 !== 1'b1) begin failures++; $display("FAIL load1_q1 got=%b exp=1", q1); end
        checks++;
        if (qn1 !== 1'b0) begin failures++; $display("FAIL load1_qn1 got=%b exp=0", qn1); end
        checks++;
        if (q8 !== 8'h3C) begin failures++; $display("FAIL load_q8 got=%h exp=3c", q8); end
        checks++;
        if (qn8 !== 8'hC3) begin failures++; $display("FAIL load_qn8 got=%h exp=c3", qn8); end
        @(negedge C);
        d1 = 1'b0; d8 = 8'h81;
        @(posedge C); #1;
        checks++;
        if (q1 !== 1'b0) begin failures++; $display("FAIL load0_q1 got=%b exp=0", q1); end
        checks++;
        if (qn1 !== 1'b1) begin failures++; $display("FAIL load0_qn1 got=%b exp=1", qn1); end
        checks++;
        if (q8 !== 8'h81) begin failures++; $display("FAIL load2_q8 got=%h exp=81", q8); end
    endtask

    task automatic test_hold();
        @(negedge C);
        EN = 1'b1; d1 = 1'b1; d8 = 8'hE7;
        @(posedge C); #1;
        @(negedge C);
        EN = 1'b0; d1 = 1'b0; d8 = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(posedge C); #1;
            checks++;
            if (q1 !== 1'b1) begin failures++; $display("FAIL hold_q1[%0d] got=%b exp=1", k, q1); end
            checks++;
            if (q8 !== 8'hE7) begin failures++; $display("FAIL hold_q8[%0d] got=%h exp=e7", k, q8); end
        end
    endtask

    task automatic test_edge();
        @(negedge C);
        EN = 1'b1; d1 = 1'b0;
        @(posedge C); #1;
        checks++;
        if (q1 !== 1'b0) begin failures++; $display("FAIL edge_pre_q1 got=%b exp=0", q1); end
        // Pulse D fully inside the period
        #10 d1 = 1'b1;
        #20;
        checks++;
        if (q1 !== 1'b0) begin failures++; $display("FAIL edge_mid_q1 got=%b exp=0", q1); end
        d1 = 1'b0;
        @(posedge C); #1;
        checks++;
        if (q1 !== 1'b0) begin failures++; $display("FAIL edge_post_q1 got=%b exp=0", q1); end
    endtask

    task automatic test_rst_priority();
        @(negedge C);
        EN = 1'b1; d1 = 1'b1; d8 = 8'h11;
        @(posedge C); #1;
        @(negedge C);
        rst = 1'b1; EN = 1'b1; d1 = 1'b1; d8 = 8'hFF;
        @(posedge C); #1;
        checks++;
        if (q1 !== 1'b0) begin failures++; $display("FAIL rstpri_q1 got=%b exp=0", q1); end
        checks++;
        if (q8 !== 8'hA5) begin failures++; $display("FAIL rstpri_q8 got=%h exp=a5", q8); end
        // Reload, then assert reset mid-period
        @(negedge C);
        rst = 1'b0; d8 = 8'h42;
        @(posedge C); #1;
        #10 rst = 1'b1;
        #10;
        checks++;
        if (q1 !== 1'b1) begin failures++; $display("FAIL rstmid_q1 got=%b exp=1", q1); end
        checks++;
        if (q8 !== 8'h42) begin failures++; $display("FAIL rstmid_q8 got=%h exp=42", q8); end
        @(posedge C); #1;
        checks++;
        if (q1 !== 1'b0) begin failures++; $display("FAIL rstnext_q1 got=%b exp=0", q1); end
        checks++;
        if (qn8 !== 8'h5A) begin failures++; $display("FAIL rstnext_qn8 got=%h exp=5a", qn8); end
        @(negedge C);
        rst = 1'b0; EN = 1'b0;
    endtask

`ifdef D_EN_SR_EN
    task automatic test_set_clear();
        @(negedge C);
        EN = 1'b0; d4 = 4'h9; S = 1'b1; R = 1'b0;
        @(posedge C); #1;
        checks++;
        if (q4 !== 4'hF) begin failures++; $display("FAIL set_q4 got=%h exp=f", q4); end
        checks++;
        if (qn4 !== 4'h0) begin failures++; $display("FAIL set_qn4 got=%h exp=0", qn4); end
        @(negedge C);
        S = 1'b1; R = 1'b1; EN = 1'b1;
        @(posedge C); #1;
        checks++;
        if (q4 !== 4'h0) begin failures++; $display("FAIL setclr_q4 got=%h exp=0", q4); end
        @(negedge C);
        rst = 1'b1; S = 1'b1; R = 1'b0;
        @(posedge C); #1;
        checks++;
        if (q4 !== 4'h6) begin failures++; $display("FAIL rstset_q4 got=%h exp=6", q4); end
        @(negedge C);
        rst = 1'b0; S = 1'b1;
        @(posedge C); #1;
        @(negedge C);
        S = 1'b0; R = 1'b0; EN = 1'b0; d4 = 4'h3;
        @(posedge C); #1;
        checks++;
        if (q4 !== 4'hF) begin failures++; $display("FAIL srhold_q4 got=%h exp=f", q4); end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1; EN = 1'b0; d1 = 1'b0; d8 = 8'h00;
`ifdef D_EN_SR_EN
        S = 1'b0; R = 1'b0; d4 = 4'h0;
`endif
        test_reset();
        test_load();
        test_hold();
        test_edge();
        test_rst_priority();
`ifdef D_EN_SR_EN
        test_set_clear();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_d_en
`default_nettype wire
